// File: rtl/joy_serial_rx.sv
// rtl/joy_serial_rx.sv - DB9 splitter serial receiver: shift clock, load strobe, 24-bit frame deserialiser.
// Optional two-frame output debounce when JOY_DEBOUNCE_EN is defined.
`timescale 1ns/1ps
module joy_serial_rx #(
  parameter int CLK_DIV = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [11:0] joystick1,
  output logic [11:0] joystick2,
  output logic        frame_valid
);

  localparam logic [7:0] DIV_MAX  = 8'(CLK_DIV - 1);
  localparam logic [4:0] SLOT_MAX = 5'd25;

  logic [7:0]  div_q, div_d;
  logic        clk_q, clk_d;
  logic        load_q, load_d;
  logic [4:0]  slot_q, slot_d, slot_next;
  logic        primed_q, primed_d;
  logic [11:0] sh1_q, sh1_d, sh2_q, sh2_d;
  logic [11:0] j1_q, j1_d, j2_q, j2_d;
  logic        fv_q, fv_d;
  logic        wrap, rise, complete;
`ifdef JOY_DEBOUNCE_EN
  logic [23:0] cand_q, cand_d;
`endif

  always_comb begin
    div_d     = div_q;
    clk_d     = clk_q;
    load_d    = load_q;
    slot_d    = slot_q;
    primed_d  = primed_q;
    sh1_d     = sh1_q;
    sh2_d     = sh2_q;
    j1_d      = j1_q;
    j2_d      = j2_q;
    fv_d      = 1'b0;
    slot_next = slot_q;
    complete  = 1'b0;
`ifdef JOY_DEBOUNCE_EN
    cand_d    = cand_q;
`endif

    wrap  = (div_q == DIV_MAX);
    div_d = wrap ? 8'd0 : div_q + 8'd1;
    if (wrap) clk_d = ~clk_q;
    rise = wrap & ~clk_q;

    if (rise) begin
      // Shadow bit placement follows the splitter's shift order.
      case (slot_q)
        5'd2:  sh1_d[8]  = JOY_DATA;
        5'd3:  sh1_d[6]  = JOY_DATA;
        5'd4:  sh1_d[5]  = JOY_DATA;
        5'd5:  sh1_d[4]  = JOY_DATA;
        5'd6:  sh1_d[3]  = JOY_DATA;
        5'd7:  sh1_d[2]  = JOY_DATA;
        5'd8:  sh1_d[1]  = JOY_DATA;
        5'd9:  sh1_d[0]  = JOY_DATA;
        5'd10: sh2_d[8]  = JOY_DATA;
        5'd11: sh2_d[6]  = JOY_DATA;
        5'd12: sh2_d[5]  = JOY_DATA;
        5'd13: sh2_d[4]  = JOY_DATA;
        5'd14: sh2_d[3]  = JOY_DATA;
        5'd15: sh2_d[2]  = JOY_DATA;
        5'd16: sh2_d[1]  = JOY_DATA;
        5'd17: sh2_d[0]  = JOY_DATA;
        5'd18: sh2_d[10] = JOY_DATA;
        5'd19: sh2_d[11] = JOY_DATA;
        5'd20: sh2_d[9]  = JOY_DATA;
        5'd21: sh2_d[7]  = JOY_DATA;
        5'd22: sh1_d[10] = JOY_DATA;
        5'd23: sh1_d[11] = JOY_DATA;
        5'd24: sh1_d[9]  = JOY_DATA;
        5'd25: sh1_d[7]  = JOY_DATA;
        default: ;
      endcase

      slot_next = (slot_q == SLOT_MAX) ? 5'd0 : slot_q + 5'd1;
      slot_d    = slot_next;
      load_d    = (slot_next != 5'd0);
      if (slot_next == 5'd0) primed_d = 1'b1;
      complete  = (slot_q == SLOT_MAX) && primed_q;
    end

    if (complete) begin
`ifdef JOY_DEBOUNCE_EN
      // Publish only once the same frame has been seen twice in a row.
      cand_d = {sh2_d, sh1_d};
      if ({sh2_d, sh1_d} == cand_q) begin
        j1_d = sh1_d;
        j2_d = sh2_d;
        fv_d = 1'b1;
      end
`else
      j1_d = sh1_d;
      j2_d = sh2_d;
      fv_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= 8'd0;
      clk_q    <= 1'b0;
      load_q   <= 1'b1;
      slot_q   <= SLOT_MAX;
      primed_q <= 1'b0;
      sh1_q    <= 12'hFFF;
      sh2_q    <= 12'hFFF;
      j1_q     <= 12'hFFF;
      j2_q     <= 12'hFFF;
      fv_q     <= 1'b0;
`ifdef JOY_DEBOUNCE_EN
      cand_q   <= 24'hFFFFFF;
`endif
    end else begin
      div_q    <= div_d;
      clk_q    <= clk_d;
      load_q   <= load_d;
      slot_q   <= slot_d;
      primed_q <= primed_d;
      sh1_q    <= sh1_d;
      sh2_q    <= sh2_d;
      j1_q     <= j1_d;
      j2_q     <= j2_d;
      fv_q     <= fv_d;
`ifdef JOY_DEBOUNCE_EN
      cand_q   <= cand_d;
`endif
    end
  end

  assign JOY_CLK     = clk_q;
  assign JOY_LOAD    = load_q;
  assign joystick1   = j1_q;
  assign joystick2   = j2_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_joy_serial_rx.sv
// tb/tb_joy_serial_rx.sv - scoreboard bench for joy_serial_rx with a behavioural splitter model.
// Runs a CLK_DIV=2 instance for data tests and a CLK_DIV=1 instance for the divider boundary.
`timescale 1ns/1ps
module tb_joy_serial_rx;

  localparam int DIV_A = 2;
  localparam int DIV_B = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic data_a = 1'b1, data_b = 1'b1;
  logic a_clk, a_load, a_fv, b_clk, b_load, b_fv;
  logic [11:0] a_j1, a_j2, b_j1, b_j2;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  logic [23:0] exp_q[$];
  logic [25:0] pend_q[$];
  int outstanding = 0;
  int slot_a = 25;
  int slot_b = 25;
  logic [25:0] fr_b;

  joy_serial_rx #(.CLK_DIV(DIV_A)) dut_a (
    .clk(clk), .reset(reset), .JOY_DATA(data_a), .JOY_CLK(a_clk), .JOY_LOAD(a_load),
    .joystick1(a_j1), .joystick2(a_j2), .frame_valid(a_fv));

  joy_serial_rx #(.CLK_DIV(DIV_B)) dut_b (
    .clk(clk), .reset(reset), .JOY_DATA(data_b), .JOY_CLK(b_clk), .JOY_LOAD(b_load),
    .joystick1(b_j1), .joystick2(b_j2), .frame_valid(b_fv));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] map_frame(input logic [25:0] f);
    logic [11:0] j1;
    logic [11:0] j2;
    j1 = 12'hFFF;
    j2 = 12'hFFF;
    j1[8] = f[2];  j1[6] = f[3];  j1[5] = f[4];  j1[4] = f[5];
    j1[3] = f[6];  j1[2] = f[7];  j1[1] = f[8];  j1[0] = f[9];
    j2[8] = f[10]; j2[6] = f[11]; j2[5] = f[12]; j2[4] = f[13];
    j2[3] = f[14]; j2[2] = f[15]; j2[1] = f[16]; j2[0] = f[17];
    j2[10] = f[18]; j2[11] = f[19]; j2[9] = f[20]; j2[7] = f[21];
    j1[10] = f[22]; j1[11] = f[23]; j1[9] = f[24]; j1[7] = f[25];
    return {j2, j1};
  endfunction

  // Splitter model for instance A: loads a frame while JOY_LOAD is low, shifts on each JOY_CLK rise.
  initial begin
    logic prev;
    logic primed;
    logic tag;
    logic [25:0] cur;
    logic [23:0] cand;
    logic [23:0] v;
    prev = 1'b0; primed = 1'b0; tag = 1'b0; cur = '1; cand = '1;
    forever begin
      @(negedge clk);
      if (reset) begin
        slot_a = 25; primed = 1'b0; cur = '1; tag = 1'b0; cand = '1;
        exp_q.delete(); pend_q.delete(); outstanding = 0;
      end else if (a_clk && !prev) begin
        if (!a_load) begin
          if (primed) begin
            v = map_frame(cur);
`ifdef JOY_DEBOUNCE_EN
            if (v == cand) exp_q.push_back(v);
            cand = v;
`else
            exp_q.push_back(v);
`endif
            if (tag) outstanding--;
          end
          primed = 1'b1;
          slot_a = 0;
          if (pend_q.size() > 0) begin
            cur = pend_q.pop_front();
            tag = 1'b1;
          end else begin
            cur = '1;
            tag = 1'b0;
          end
        end else if (slot_a < 25) begin
          slot_a++;
        end
      end
      prev = a_clk;
      data_a = cur[slot_a];
    end
  end

  // Splitter model for instance B: same constant frame every scan.
  initial begin
    logic prev;
    prev = 1'b0;
    fr_b = '1;
    fr_b[3] = 1'b0;
    fr_b[20] = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) slot_b = 25;
      else if (b_clk && !prev) begin
        if (!b_load) slot_b = 0;
        else if (slot_b < 25) slot_b++;
      end
      prev = b_clk;
      data_b = fr_b[slot_b];
    end
  end

  task automatic tick();
    @(posedge clk);
    #7;
  endtask

  task automatic send(input logic [25:0] f);
    pend_q.push_back(f);
    outstanding++;
  endtask

  task automatic drain(input string nm, input int limit, output int npulse, output int nlow);
    int t;
    logic [23:0] e;
    t = 0; npulse = 0; nlow = 0;
    exp_q.delete();
    while ((outstanding > 0 || exp_q.size() > 0) && t < limit) begin
      tick();
      t++;
      if (a_fv) begin
        npulse++;
        if ({a_j2, a_j1} != 24'hFFFFFF) nlow++;
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s unexpected frame_valid: got j1=%h j2=%h want no write", nm, a_j1, a_j2);
        end else begin
          e = exp_q.pop_front();
          if ({a_j2, a_j1} !== e)
            $display("FAIL %s frame data: got j1=%h j2=%h want j1=%h j2=%h", nm, a_j1, a_j2, e[11:0], e[23:12]);
          else passed++;
        end
      end
    end
    checks++;
    if (t >= limit) $display("FAIL %s timeout: got %0d cycles want < %0d", nm, t, limit);
    else passed++;
  endtask

  task automatic test_reset();
    int t;
    int low;
    reset = 1'b1;
    repeat (10) tick();
    checks++; if (a_clk !== 1'b0) $display("FAIL reset JOY_CLK: got %b want 0", a_clk); else passed++;
    checks++; if (a_load !== 1'b1) $display("FAIL reset JOY_LOAD: got %b want 1", a_load); else passed++;
    checks++; if (a_j1 !== 12'hFFF) $display("FAIL reset joystick1: got %h want fff", a_j1); else passed++;
    checks++; if (a_j2 !== 12'hFFF) $display("FAIL reset joystick2: got %h want fff", a_j2); else passed++;
    checks++; if (a_fv !== 1'b0) $display("FAIL reset frame_valid: got %b want 0", a_fv); else passed++;
    reset = 1'b0;
    t = 0;
    while (a_load && t < 100) begin tick(); t++; end
    low = 0;
    while (!a_load && t < 100) begin tick(); t++; low++; end
    checks++;
    if (low !== 2 * DIV_A) $display("FAIL load_pulse width: got %0d want %0d", low, 2 * DIV_A);
    else passed++;
  endtask

  task automatic test_single_frame();
    logic [25:0] f;
    int np, nl;
    f = '1; f[2] = 1'b0; f[25] = 1'b0;
    send(f);
`ifdef JOY_DEBOUNCE_EN
    send(f);
`endif
    drain("single", 400, np, nl);
    checks++; if (a_j1 !== 12'hE7F) $display("FAIL single joystick1: got %h want e7f", a_j1); else passed++;
    checks++; if (a_j2 !== 12'hFFF) $display("FAIL single joystick2: got %h want fff", a_j2); else passed++;
    tick();
    checks++; if (a_fv !== 1'b0) $display("FAIL single pulse width: got %b want 0", a_fv); else passed++;
    checks++; if (a_j1 !== 12'hE7F) $display("FAIL single hold: got %h want e7f", a_j1); else passed++;
  endtask

  task automatic test_bit_map();
    logic [25:0] f;
    int np, nl;
    for (int s = 1; s <= 25; s++) begin
      f = '1;
      f[s] = 1'b0;
      send(f);
`ifdef JOY_DEBOUNCE_EN
      send(f);
`endif
    end
    drain("bitmap", 6000, np, nl);
    checks++;
    if (nl < 24) $display("FAIL bitmap low_frames: got %0d want >= 24", nl);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [25:0] f;
    int np, nl, n;
    logic [23:0] e;
    f = '1;
    for (int s = 10; s <= 21; s++) f[s] = 1'b0;
    send(f);
    send(f);
    drain("pre_reset", 500, np, nl);
    checks++; if (a_j2 !== 12'h000) $display("FAIL pre_reset joystick2: got %h want 000", a_j2); else passed++;
    checks++; if (a_j1 !== 12'hFFF) $display("FAIL pre_reset joystick1: got %h want fff", a_j1); else passed++;
    n = 0;
    while (slot_a != 12 && n < 300) begin tick(); n++; end
    checks++; if (slot_a != 12) $display("FAIL mid_reset slot wait: got %0d want 12", slot_a); else passed++;
    reset = 1'b1;
    #1;
    checks++; if (a_j2 !== 12'hFFF) $display("FAIL mid_reset joystick2: got %h want fff", a_j2); else passed++;
    checks++; if (a_j1 !== 12'hFFF) $display("FAIL mid_reset joystick1: got %h want fff", a_j1); else passed++;
    checks++; if (a_load !== 1'b1) $display("FAIL mid_reset JOY_LOAD: got %b want 1", a_load); else passed++;
    repeat (3) tick();
    reset = 1'b0;
    n = 0;
    while (!a_fv && n < 400) begin tick(); n++; end
    checks++;
    if (n !== 53 * DIV_A) $display("FAIL mid_reset first update: got %0d cycles want %0d", n, 53 * DIV_A);
    else passed++;
    checks++;
    if (exp_q.size() == 0) $display("FAIL mid_reset scoreboard: got empty want one frame");
    else begin
      e = exp_q.pop_front();
      if ({a_j2, a_j1} !== e) $display("FAIL mid_reset frame: got %h want %h", {a_j2, a_j1}, e);
      else passed++;
    end
  endtask

`ifdef JOY_DEBOUNCE_EN
  task automatic test_debounce();
    logic [25:0] fa, fb;
    int np, nl;
    fa = '1; fa[10] = 1'b0;
    fb = '1; fb[5] = 1'b0;
    send(fa);
    send(fb);
    send(fb);
    drain("debounce", 600, np, nl);
    checks++; if (nl !== 1) $display("FAIL debounce writes: got %0d want 1", nl); else passed++;
    checks++; if (a_j1 !== 12'hFEF) $display("FAIL debounce joystick1: got %h want fef", a_j1); else passed++;
    checks++; if (a_j2 !== 12'hFFF) $display("FAIL debounce joystick2: got %h want fff", a_j2); else passed++;
  endtask
`endif

  task automatic test_divider();
    logic p;
    int n, t0;
    p = b_clk;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (b_clk !== ~p) $display("FAIL div1 toggle: got %b want %b", b_clk, ~p);
      else passed++;
      p = b_clk;
    end
    n = 0;
    while (!b_fv && n < 200) begin tick(); n++; end
    t0 = cyc;
    tick();
    n = 0;
    while (!b_fv && n < 200) begin tick(); n++; end
    checks++; if (cyc - t0 !== 52) $display("FAIL div1 frame period: got %0d want 52", cyc - t0); else passed++;
    checks++; if (b_j1 !== 12'hFBF) $display("FAIL div1 joystick1: got %h want fbf", b_j1); else passed++;
    checks++; if (b_j2 !== 12'hDFF) $display("FAIL div1 joystick2: got %h want dff", b_j2); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_bit_map();
    test_reset_mid();
`ifdef JOY_DEBOUNCE_EN
    test_debounce();
`endif
    test_divider();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
